// File: rtl/nbit_comparator_pkg.sv
// Shared compare-result encoding and helpers for nbit_comparator.
package nbit_comparator_pkg;

  typedef logic [1:0] cmp_res_t;

  localparam cmp_res_t CMP_EQ = 2'b00;
  localparam cmp_res_t CMP_GT = 2'b01;
  localparam cmp_res_t CMP_LT = 2'b10;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_flags_t;

  // The illegal 2'b11 code decodes to no flags rather than aliasing a legal one.
  function automatic cmp_flags_t res_to_flags(cmp_res_t r);
    cmp_flags_t f;
    f.gt = (r == CMP_GT);
    f.lt = (r == CMP_LT);
    f.eq = (r == CMP_EQ);
    return f;
  endfunction

endpackage

// File: rtl/nbit_cmp_cell.sv
// Merge cell: the more significant slice wins unless it compared equal.
module nbit_cmp_cell
  import nbit_comparator_pkg::*;
(
  input  cmp_res_t hi,
  input  cmp_res_t lo,
  output cmp_res_t res
);

  assign res = (hi == CMP_EQ) ? lo : hi;

endmodule

// File: rtl/nbit_comparator.sv
// Registered WIDTH-bit magnitude comparator built on a balanced merge tree.
module nbit_comparator
  import nbit_comparator_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             a_greater,
  output logic             a_lesser,
  output logic             equal
);

  localparam int LOG = $clog2(WIDTH);
  localparam int P   = 1 << LOG;
  localparam int PAD = P - WIDTH;
  localparam logic [WIDTH-1:0] MSB_MASK = SIGNED ? (WIDTH'(1) << (WIDTH-1)) : '0;

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  logic [WIDTH-1:0] a_m, b_m;
  assign a_m = a ^ MSB_MASK;
  assign b_m = b ^ MSB_MASK;

  // Heap-ordered tree: node[0] is the root, leaves at node[P-1 .. 2P-2].
  // Leaf slot k holds bit P-1-k; padding slots sit above the MSB.
  cmp_res_t node [0:2*P-2];

  for (genvar k = 0; k < P; k++) begin : g_leaf
    if (k >= PAD) begin : g_real
      assign node[P-1+k] = (a_m[P-1-k] & ~b_m[P-1-k]) ? CMP_GT :
                           (~a_m[P-1-k] & b_m[P-1-k]) ? CMP_LT : CMP_EQ;
    end else begin : g_pad
      assign node[P-1+k] = CMP_EQ;
    end
  end

  // Nodes whose high half is all padding forward the low half directly,
  // leaving exactly WIDTH-1 real merge cells.
  for (genvar l = 0; l < LOG; l++) begin : g_lvl
    for (genvar p = 0; p < (1 << l); p++) begin : g_node
      localparam int I        = (1 << l) - 1 + p;
      localparam int SPAN     = P >> l;
      localparam bit ANY_REAL = (p*SPAN + SPAN - 1) >= PAD;
      localparam bit HI_REAL  = (p*SPAN + SPAN/2 - 1) >= PAD;
      if (!ANY_REAL) begin : g_eq
        assign node[I] = CMP_EQ;
      end else if (!HI_REAL) begin : g_pass
        assign node[I] = node[2*I+2];
      end else begin : g_cell
        nbit_cmp_cell u_cell (
          .hi  (node[2*I+1]),
          .lo  (node[2*I+2]),
          .res (node[I])
        );
      end
    end
  end

  cmp_flags_t flags_d;
  assign flags_d = res_to_flags(node[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      a_greater <= 1'b0;
      a_lesser  <= 1'b0;
      equal     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        a_greater <= flags_d.gt;
        a_lesser  <= flags_d.lt;
        equal     <= flags_d.eq;
      end
    end
  end

endmodule

// File: tb/tb_nbit_comparator.sv
// Directed-table plus random reference-model bench for nbit_comparator.
module tb_nbit_comparator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [4:0] a5 = '0, b5 = '0;
  logic [0:0] a1 = '0, b1 = '0;

  logic ov_u, gt_u, lt_u, eq_u;
  logic ov_s, gt_s, lt_s, eq_s;
  logic ov_5, gt_5, lt_5, eq_5;
  logic ov_1, gt_1, lt_1, eq_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nbit_comparator #(.WIDTH(8), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8),
    .out_valid(ov_u), .a_greater(gt_u), .a_lesser(lt_u), .equal(eq_u));
  nbit_comparator #(.WIDTH(8), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8),
    .out_valid(ov_s), .a_greater(gt_s), .a_lesser(lt_s), .equal(eq_s));
  nbit_comparator #(.WIDTH(5), .SIGNED(1'b0)) dut_5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a5), .b(b5),
    .out_valid(ov_5), .a_greater(gt_5), .a_lesser(lt_5), .equal(eq_5));
  nbit_comparator #(.WIDTH(1), .SIGNED(1'b0)) dut_1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1),
    .out_valid(ov_1), .a_greater(gt_1), .a_lesser(lt_1), .equal(eq_1));

  // Expected codes are {gt, lt, eq}
  localparam logic [2:0] GT = 3'b100, LT = 3'b010, EQ = 3'b001;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] exp_u;
    logic [2:0] exp_s;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {ov,gt,lt,eq}=%b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input int x, input int y);
    if (x > y) return GT;
    if (x < y) return LT;
    return EQ;
  endfunction

  logic [2:0] e_u, e_s, e_5, e_1;
  logic       iv;

  initial begin
    vecs[0] = '{8'h80, 8'h7F, GT, LT};
    vecs[1] = '{8'hFF, 8'hFE, GT, GT};
    vecs[2] = '{8'h01, 8'h00, GT, GT};
    vecs[3] = '{8'h00, 8'h01, LT, LT};
    vecs[4] = '{8'h5A, 8'h5A, EQ, EQ};
    vecs[5] = '{8'h7F, 8'h80, LT, GT};
    vecs[6] = '{8'hFF, 8'h00, GT, LT};
    vecs[7] = '{8'h00, 8'hFF, LT, GT};
    vecs[8] = '{8'h10, 8'h11, LT, LT};
    vecs[9] = '{8'hC8, 8'h11, GT, LT};

    // Reset state, then first beat right after release
    repeat (2) tick();
    check("reset_u", {ov_u, gt_u, lt_u, eq_u}, 4'b0000);
    check("reset_s", {ov_s, gt_s, lt_s, eq_s}, 4'b0000);
    rst_n = 1'b1;
    a8 = 8'd0; b8 = 8'd0; in_valid = 1'b1;
    tick();
    check("first_eq_u", {ov_u, gt_u, lt_u, eq_u}, {1'b1, EQ});
    check("first_eq_s", {ov_s, gt_s, lt_s, eq_s}, {1'b1, EQ});

    for (int i = 0; i < 10; i++) begin
      a8 = vecs[i].a; b8 = vecs[i].b; in_valid = 1'b1;
      tick();
      check($sformatf("tbl%0d_u", i), {ov_u, gt_u, lt_u, eq_u}, {1'b1, vecs[i].exp_u});
      check($sformatf("tbl%0d_s", i), {ov_s, gt_s, lt_s, eq_s}, {1'b1, vecs[i].exp_s});
    end

    // Back-to-back ordering, then flags hold once in_valid drops
    a8 = 8'd200; b8 = 8'd17;  tick(); check("b2b_gt", {ov_u, gt_u, lt_u, eq_u}, {1'b1, GT});
    a8 = 8'd17;  b8 = 8'd200; tick(); check("b2b_lt", {ov_u, gt_u, lt_u, eq_u}, {1'b1, LT});
    a8 = 8'd255; b8 = 8'd255; tick(); check("b2b_eq", {ov_u, gt_u, lt_u, eq_u}, {1'b1, EQ});
    a8 = 8'd0;   b8 = 8'd255; tick(); check("b2b_lt2", {ov_u, gt_u, lt_u, eq_u}, {1'b1, LT});
    in_valid = 1'b0; a8 = 8'd99; b8 = 8'd1;
    tick(); check("hold1", {ov_u, gt_u, lt_u, eq_u}, {1'b0, LT});
    tick(); check("hold2", {ov_u, gt_u, lt_u, eq_u}, {1'b0, LT});

    // Asynchronous reset between edges
    a8 = 8'h01; b8 = 8'h00; in_valid = 1'b1;
    tick(); check("pre_rst_gt", {ov_u, gt_u, lt_u, eq_u}, {1'b1, GT});
    #2 rst_n = 1'b0;
    #1 check("async_rst_u", {ov_u, gt_u, lt_u, eq_u}, 4'b0000);
    check("async_rst_s", {ov_s, gt_s, lt_s, eq_s}, 4'b0000);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick(); check("post_rst_idle", {ov_u, gt_u, lt_u, eq_u}, 4'b0000);
    a8 = 8'h10; b8 = 8'h11; in_valid = 1'b1;
    tick(); check("post_rst_beat", {ov_u, gt_u, lt_u, eq_u}, {1'b1, LT});

    // Random beats against a behavioural model, starting from a clean reset
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    e_u = '0; e_s = '0; e_5 = '0; e_1 = '0;
    for (int n = 0; n < 10000; n++) begin
      iv = 1'($urandom_range(0, 1));
      a8 = 8'($urandom); b8 = 8'($urandom);
      a5 = 5'($urandom); b5 = 5'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom);
      in_valid = iv;
      tick();
      if (iv) begin
        e_u = ref_cmp(int'(a8), int'(b8));
        e_s = ref_cmp(int'($signed(a8)), int'($signed(b8)));
        e_5 = ref_cmp(int'(a5), int'(b5));
        e_1 = ref_cmp(int'(a1), int'(b1));
      end
      check("rnd_u8", {ov_u, gt_u, lt_u, eq_u}, {iv, e_u});
      check("rnd_s8", {ov_s, gt_s, lt_s, eq_s}, {iv, e_s});
      check("rnd_w5", {ov_5, gt_5, lt_5, eq_5}, {iv, e_5});
      check("rnd_w1", {ov_1, gt_1, lt_1, eq_1}, {iv, e_1});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
